lutram_burst_reader: RTL

//  Burst read engine for a bank of WIDTH x RAMD64E-style distributed-RAM columns.

---
 rtl/lutram_burst_reader.sv | 150 +++++++++++++++
 1 files changed

// File: rtl/lutram_burst_reader.sv
// Burst read engine for a bank of distributed-RAM columns: drives the shared read address,
// captures the asynchronous read data and streams words out through a 2-entry skid buffer.
module lutram_burst_reader #(
  parameter int unsigned WIDTH      = 8,
  parameter int unsigned DEPTH_LOG2 = 6,
  parameter int unsigned LEN_BITS   = 9
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  cmd_valid,
  output logic                  cmd_ready,
  input  logic [DEPTH_LOG2-1:0] cmd_addr,
  input  logic [LEN_BITS-1:0]   cmd_len,
  output logic [DEPTH_LOG2-1:0] radr,
  input  logic [WIDTH-1:0]      rdata,
  output logic                  m_valid,
  input  logic                  m_ready,
  output logic [WIDTH-1:0]      m_data,
  output logic                  m_last,
  output logic                  busy,
  output logic                  done
);

  typedef enum logic [1:0] {StIdle, StRun, StDrain} state_e;

  state_e                state_q, state_d;
  logic [DEPTH_LOG2-1:0] radr_q, radr_d;
  logic [LEN_BITS-1:0]   rem_q, rem_d;
  logic [1:0]            cnt_q, cnt_d;
  logic [WIDTH-1:0]      main_data_q, main_data_d, skid_data_q, skid_data_d;
  logic                  main_last_q, main_last_d, skid_last_q, skid_last_d;
  logic                  done_q, done_d;

  logic pop, cap, cap_last, accept;

  assign m_valid   = (cnt_q != 2'd0);
  assign m_data    = main_data_q;
  assign m_last    = m_valid & main_last_q;
  assign radr      = radr_q;
  assign cmd_ready = (state_q == StIdle);
  assign busy      = (state_q != StIdle);
  assign done      = done_q;

  assign pop      = m_valid & m_ready;
  // A slot frees up this edge if the buffer is not full or the head is being taken.
  assign cap      = (state_q == StRun) && ((cnt_q != 2'd2) || pop);
  assign cap_last = (rem_q == LEN_BITS'(1));
  assign accept   = cmd_valid & (state_q == StIdle);

  always_comb begin
    state_d = state_q;
    radr_d  = radr_q;
    rem_d   = rem_q;
    done_d  = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (accept) begin
          if (cmd_len != '0) begin
            radr_d  = cmd_addr;
            rem_d   = cmd_len;
            state_d = StRun;
          end else begin
            done_d = 1'b1;
          end
        end
      end
      StRun: begin
        if (cap) begin
          radr_d = radr_q + DEPTH_LOG2'(1);
          rem_d  = rem_q - LEN_BITS'(1);
          if (cap_last) state_d = StDrain;
        end
      end
      StDrain: begin
        if (pop && main_last_q) begin
          state_d = StIdle;
          done_d  = 1'b1;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    cnt_d       = cnt_q;
    main_data_d = main_data_q;
    main_last_d = main_last_q;
    skid_data_d = skid_data_q;
    skid_last_d = skid_last_q;
    case (cnt_q)
      2'd0: begin
        if (cap) begin
          main_data_d = rdata;
          main_last_d = cap_last;
          cnt_d       = 2'd1;
        end
      end
      2'd1: begin
        if (pop && cap) begin
          main_data_d = rdata;
          main_last_d = cap_last;
        end else if (pop) begin
          cnt_d = 2'd0;
        end else if (cap) begin
          skid_data_d = rdata;
          skid_last_d = cap_last;
          cnt_d       = 2'd2;
        end
      end
      2'd2: begin
        if (pop) begin
          main_data_d = skid_data_q;
          main_last_d = skid_last_q;
          if (cap) begin
            skid_data_d = rdata;
            skid_last_d = cap_last;
          end else begin
            cnt_d = 2'd1;
          end
        end
      end
      default: cnt_d = 2'd0;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= StIdle;
      radr_q      <= '0;
      rem_q       <= '0;
      cnt_q       <= 2'd0;
      main_data_q <= '0;
      main_last_q <= 1'b0;
      skid_data_q <= '0;
      skid_last_q <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      radr_q      <= radr_d;
      rem_q       <= rem_d;
      cnt_q       <= cnt_d;
      main_data_q <= main_data_d;
      main_last_q <= main_last_d;
      skid_data_q <= skid_data_d;
      skid_last_q <= skid_last_d;
      done_q      <= done_d;
    end
  end

endmodule
